// File: rtl/csa_pkg.sv
// Shared helpers for csa_pipe_adder: clog2, parameter legality and derived sizes.
package csa_pkg;

   function automatic int unsigned csa_clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (v > 0) ? v - 1 : 0;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic bit csa_params_ok(input int unsigned w, input int unsigned blk,
                                        input int unsigned bps);
      return (blk >= 2) && (bps >= 1) && (w > 0) && ((w % (blk * bps)) == 0);
   endfunction

   // Derived sizes fall back to 1 on illegal parameters so elaboration reaches the check.
   function automatic int unsigned csa_nblk(input int unsigned w, input int unsigned blk);
      return (blk >= 2) ? w / blk : 1;
   endfunction

   function automatic int unsigned csa_lat(input int unsigned w, input int unsigned blk,
                                           input int unsigned bps);
      return csa_params_ok(w, blk, bps) ? csa_nblk(w, blk) / bps : 1;
   endfunction

   function automatic int unsigned csa_skw(input int unsigned w, input int unsigned blk);
      return csa_clog2(csa_nblk(w, blk) + 1);
   endfunction

endpackage

// File: rtl/csa_skip_block.sv
// One carry-skip block: BLK-bit ripple adder whose carry-out bypasses the
// ripple chain when every bit propagates.
module csa_skip_block #(
   parameter int unsigned BLK = 4
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           cin,
   output logic [BLK-1:0] sum,
   output logic           cout
);

   logic [BLK:0]   rc;
   logic [BLK-1:0] prop;
   logic           p;

   assign prop = a ^ b;
   assign p    = &prop;

   always_comb begin
      sum   = '0;
      rc    = '0;
      rc[0] = cin;
      for (int i = 0; i < int'(BLK); i++) begin
         sum[i]  = prop[i] ^ rc[i];
         rc[i+1] = (a[i] & b[i]) | (rc[i] & prop[i]);
      end
   end

   assign cout = p ? cin : rc[BLK];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-skip adder/subtractor with valid/ready handshake on both sides.
// Define CSA_SKIP_STATS_EN to add the skip_cnt/stats_clr statistics ports.
module csa_pipe_adder
   import csa_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BLK            = 4,
   parameter int unsigned BLKS_PER_STAGE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
`ifdef CSA_SKIP_STATS_EN
   ,
   output logic [31:0]      skip_cnt,
   input  logic             stats_clr
`endif
);

   localparam int unsigned LAT = csa_lat(WIDTH, BLK, BLKS_PER_STAGE);
   localparam int unsigned SW  = BLK * BLKS_PER_STAGE;
`ifdef CSA_SKIP_STATS_EN
   localparam int unsigned SKW = csa_skw(WIDTH, BLK);
`endif

   if (!csa_params_ok(WIDTH, BLK, BLKS_PER_STAGE)) begin : g_bad_params
      $error("csa_pipe_adder: WIDTH must be a multiple of BLK*BLKS_PER_STAGE and BLK >= 2");
   end

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // Whole pipe advances together; it only stalls when a result is waiting.
   assign en       = out_ready | ~out_valid;
   assign in_ready = en;
   assign b_eff    = b ^ {WIDTH{sub}};
   assign c0       = cin ^ sub;

   for (genvar k = 0; k < int'(LAT); k++) begin : g_stg
      localparam int unsigned LO = k * SW;
      localparam int unsigned HI = LO + SW;

      // Unresolved operand bits entering this stage; bit 0 is stage bit LO.
      logic [WIDTH-LO-1:0]   a_in;
      logic [WIDTH-LO-1:0]   b_in;
      logic [SW-1:0]         a_s;
      logic [SW-1:0]         b_s;
      logic [SW-1:0]         sum_s;
      logic [HI-1:0]         sum_d;
      logic [BLKS_PER_STAGE:0] cy;
      logic                  vld_s;
      logic                  vld_q;
      logic                  cy_q;
      logic [HI-1:0]         sum_q;
`ifdef CSA_SKIP_STATS_EN
      logic [SKW-1:0]        skc_in;
      logic [SKW-1:0]        skc_d;
      logic [SKW-1:0]        skc_q;
`endif

      if (k == 0) begin : g_first
         assign a_in  = a;
         assign b_in  = b_eff;
         assign cy[0] = c0;
         assign vld_s = in_valid;
         assign sum_d = sum_s;
`ifdef CSA_SKIP_STATS_EN
         assign skc_in = '0;
`endif
      end else begin : g_next
         assign a_in  = g_stg[k-1].g_up.a_up_q;
         assign b_in  = g_stg[k-1].g_up.b_up_q;
         assign cy[0] = g_stg[k-1].cy_q;
         assign vld_s = g_stg[k-1].vld_q;
         assign sum_d = {sum_s, g_stg[k-1].sum_q};
`ifdef CSA_SKIP_STATS_EN
         assign skc_in = g_stg[k-1].skc_q;
`endif
      end

      assign a_s = a_in[SW-1:0];
      assign b_s = b_in[SW-1:0];

      for (genvar j = 0; j < int'(BLKS_PER_STAGE); j++) begin : g_blk
         csa_skip_block #(
            .BLK(BLK)
         ) u_blk (
            .a   (a_s[j*BLK +: BLK]),
            .b   (b_s[j*BLK +: BLK]),
            .cin (cy[j]),
            .sum (sum_s[j*BLK +: BLK]),
            .cout(cy[j+1])
         );
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            sum_q <= '0;
         end else if (en) begin
            vld_q <= vld_s;
            cy_q  <= cy[BLKS_PER_STAGE];
            sum_q <= sum_d;
         end
      end

      // Upper operand bits skew forward to the stage that resolves them.
      if (k < int'(LAT) - 1) begin : g_up
         logic [WIDTH-HI-1:0] a_up_q;
         logic [WIDTH-HI-1:0] b_up_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_up_q <= '0;
               b_up_q <= '0;
            end else if (en) begin
               a_up_q <= a_in[WIDTH-LO-1:SW];
               b_up_q <= b_in[WIDTH-LO-1:SW];
            end
         end
      end else begin : g_last
         logic c_msb;
         logic ovf_q;

         // Carry into the MSB recovered from the MSB sum bit.
         assign c_msb = sum_s[SW-1] ^ a_s[SW-1] ^ b_s[SW-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (en) begin
               ovf_q <= c_msb ^ cy[BLKS_PER_STAGE];
            end
         end
      end

`ifdef CSA_SKIP_STATS_EN
      always_comb begin
         skc_d = skc_in;
         for (int j = 0; j < int'(BLKS_PER_STAGE); j++) begin
            skc_d = skc_d + SKW'(&(a_s[j*BLK +: BLK] ^ b_s[j*BLK +: BLK]));
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            skc_q <= '0;
         end else if (en) begin
            skc_q <= skc_d;
         end
      end
`endif
   end

   assign out_valid = g_stg[LAT-1].vld_q;
   assign sum       = g_stg[LAT-1].sum_q;
   assign cout      = g_stg[LAT-1].cy_q;
   assign ovf       = g_stg[LAT-1].g_last.ovf_q;

`ifdef CSA_SKIP_STATS_EN
   logic [32:0] skip_sum;

   assign skip_sum = 33'(skip_cnt) + 33'(g_stg[LAT-1].skc_q);

   // Saturating accumulate on each handed-off result; clear wins over increment.
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         skip_cnt <= '0;
      end else if (out_valid && out_ready) begin
         skip_cnt <= skip_sum[32] ? 32'hFFFF_FFFF : skip_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboard bench for csa_pipe_adder (WIDTH=32, BLK=4, BLKS_PER_STAGE=2, LAT=4).
module tb_csa_pipe_adder;

   localparam int LAT = 4;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      bit          chk_lat;
      int          acc_cyc;
      int          tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;
`ifdef CSA_SKIP_STATS_EN
   logic [31:0] skip_cnt;
   logic        stats_clr = 1'b0;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   tag_n = 0;
   bit   done = 1'b0;
   bit   held_v = 1'b0;
   logic [31:0] held_sum = '0;
   exp_t sb[$];
   vec_t tbl[14];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   csa_pipe_adder dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf)
`ifdef CSA_SKIP_STATS_EN
      ,
      .skip_cnt (skip_cnt),
      .stats_clr(stats_clr)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t model(input logic [31:0] va, input logic [31:0] vb,
                                  input logic vc, input logic vs);
      vec_t        v;
      logic [31:0] be;
      logic [32:0] r;
      be     = vs ? ~vb : vb;
      r      = {1'b0, va} + {1'b0, be} + 33'(vc ^ vs);
      v.a    = va;
      v.b    = vb;
      v.cin  = vc;
      v.sub  = vs;
      v.sum  = r[31:0];
      v.cout = r[32];
      v.ovf  = (va[31] == be[31]) && (r[31] != va[31]);
      return v;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input vec_t v, input bit lat);
      exp_t e;
      e.sum     = v.sum;
      e.cout    = v.cout;
      e.ovf     = v.ovf;
      e.chk_lat = lat;
      e.tag     = tag_n;
      tag_n++;
      in_valid = 1'b1;
      a        = v.a;
      b        = v.b;
      cin      = v.cin;
      sub      = v.sub;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (in_ready) begin
            e.acc_cyc = cyc;
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      errors++;
      $display("FAIL send_timeout: beat %0d never accepted", e.tag);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clk);
      chk("drain_empty", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expected results on each handoff and watches stall behaviour.
   always @(negedge clk) begin
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_sum", 64'(sum), 64'(held_sum));
         end
         if (out_valid && !out_ready) chk("in_ready_stall", 64'(in_ready), 64'd0);
         if (!out_valid) chk("in_ready_idle", 64'(in_ready), 64'd1);
         held_v   = out_valid && !out_ready;
         held_sum = sum;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got sum %0h with nothing expected", sum);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk($sformatf("sum[%0d]", e.tag), 64'(sum), 64'(e.sum));
               chk($sformatf("cout[%0d]", e.tag), 64'(cout), 64'(e.cout));
               chk($sformatf("ovf[%0d]", e.tag), 64'(ovf), 64'(e.ovf));
               if (e.chk_lat) chk($sformatf("latency[%0d]", e.tag), 64'(cyc - e.acc_cyc), 64'(LAT));
            end
         end
      end
   end

   initial begin
      tbl[0]  = '{32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
      tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      tbl[5]  = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
      tbl[6]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
      tbl[7]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      tbl[8]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
      tbl[9]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0};
      tbl[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tbl[11] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      tbl[12] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
      tbl[13] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef CSA_SKIP_STATS_EN
      chk("rst_skip_cnt", 64'(skip_cnt), 64'd0);
`endif
      @(posedge clk);
      #1;

      // Single beats on an empty pipe; first one also checks latency
      send(tbl[0], 1'b1);
      drain();
      send(tbl[1], 1'b0);
      drain();
`ifdef CSA_SKIP_STATS_EN
      @(negedge clk);
      chk("skip_cnt_full_chain", 64'(skip_cnt), 64'd8);
      @(posedge clk);
      #1 stats_clr = 1'b1;
      @(posedge clk);
      #1 stats_clr = 1'b0;
      @(negedge clk);
      chk("skip_cnt_clr", 64'(skip_cnt), 64'd0);
      @(posedge clk);
      #1;
`endif
      send(tbl[2], 1'b0);
      send(tbl[3], 1'b0);
      drain();

      // Ten back-to-back beats with a 3-cycle downstream stall mid-stream
      fork
         begin
            for (int i = 4; i < 14; i++) send(tbl[i], 1'b0);
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with three beats in flight: none of them may come out
      send(tbl[4], 1'b0);
      send(tbl[5], 1'b0);
      send(tbl[6], 1'b0);
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("flush_out_valid", 64'(out_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      send(tbl[8], 1'b1);
      drain();

      // Random operands with random downstream backpressure
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               send(model($urandom(), $urandom(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1))), 1'b0);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
